// File: rtl/dsp_share_arb_pkg.sv
// Shared DSP definitions: default operand widths, requester-count limits, ID sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_share_arb_pkg;

    localparam int NREQ_DEF    = 3;
    localparam int NREQ_MIN    = 2;
    localparam int NREQ_MAX    = 4;
    localparam int A_WIDTH_DEF = 25;
    localparam int B_WIDTH_DEF = 11;

    // Never narrower than one bit, so a degenerate count still yields a legal port.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp_share_arb_rr_arbiter.sv
// Round-robin one-hot grant over NREQ requesters; search starts at the pointer.
// Latency: grant is combinational; the pointer advances on the handshake edge.
// Backpressure: no grant while en_i=0 or in reset; the pointer then holds.
module rr_arbiter
    import dsp_share_arb_pkg::*;
#(
    parameter  int NREQ     = NREQ_DEF,
    localparam int ID_WIDTH = id_width(NREQ)
) (
    input  logic                clk_3x,
    input  logic                srst_n,
    input  logic                en_i,
    input  logic [NREQ-1:0]     valid_i,
    output logic [NREQ-1:0]     grant_o,
    output logic [ID_WIDTH-1:0] grant_id_o
);

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH:0]   cand;
    logic                found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            // One extra bit so ptr+i cannot overflow before the modulo fold.
            cand = {1'b0, ptr} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NREQ))
                cand = cand - (ID_WIDTH+1)'(NREQ);
            if (!found && valid_i[cand[ID_WIDTH-1:0]]) begin
                found      = 1'b1;
                grant_id_o = cand[ID_WIDTH-1:0];
            end
        end
        if (found && en_i && srst_n)
            grant_o[grant_id_o] = 1'b1;
    end

    always_ff @(posedge clk_3x) begin
        if (!srst_n)
            ptr <= '0;
        else if (|grant_o)
            ptr <= (grant_id_o == ID_WIDTH'(NREQ-1)) ? '0 : grant_id_o + 1'b1;
    end

endmodule

// File: rtl/dsp_share_arb.sv
// Shares one multiply-add (P = A*B + C) among NREQ requesters via round-robin.
// Latency: result strobes 2 cycles after the handshake edge; 1 op/cycle.
// Backpressure: input side only via ready_o; results are never stalled.
module dsp_share_arb
    import dsp_share_arb_pkg::*;
#(
    parameter  int NREQ     = NREQ_DEF,
    parameter  int A_WIDTH  = A_WIDTH_DEF,
    parameter  int B_WIDTH  = B_WIDTH_DEF,
    localparam int P_WIDTH  = A_WIDTH + B_WIDTH,
    localparam int ID_WIDTH = id_width(NREQ)
) (
    input  logic                      clk_3x,
    input  logic                      srst_n,
    input  logic                      en_i,
    input  logic [NREQ-1:0]           valid_i,
    output logic [NREQ-1:0]           ready_o,
    input  logic [NREQ*A_WIDTH-1:0]   a_i,
    input  logic [NREQ*B_WIDTH-1:0]   b_i,
    input  logic [NREQ*P_WIDTH-1:0]   c_i,
    output logic                      res_valid_o,
    output logic [ID_WIDTH-1:0]       res_id_o,
    output logic [P_WIDTH-1:0]        res_p_o,
    output logic                      busy_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]       id;
        logic signed [A_WIDTH-1:0] a;
        logic signed [B_WIDTH-1:0] b;
        logic signed [P_WIDTH-1:0] c;
    } op_t;

    logic [ID_WIDTH-1:0]       grant_id;
    op_t                       gnt_op;
    op_t                       s1_op;
    logic                      s1_vld;
    logic                      s2_vld;
    logic signed [P_WIDTH-1:0] mac_p;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_3x     (clk_3x),
        .srst_n     (srst_n),
        .en_i       (en_i),
        .valid_i    (valid_i),
        .grant_o    (ready_o),
        .grant_id_o (grant_id)
    );

    always_comb begin
        gnt_op    = '0;
        gnt_op.id = grant_id;
        gnt_op.a  = a_i[int'(grant_id)*A_WIDTH +: A_WIDTH];
        gnt_op.b  = b_i[int'(grant_id)*B_WIDTH +: B_WIDTH];
        gnt_op.c  = c_i[int'(grant_id)*P_WIDTH +: P_WIDTH];
    end

    // Operands are sign-extended to P_WIDTH first; the exact product fits, the add wraps.
    always_comb begin
        mac_p = P_WIDTH'($signed(s1_op.a)) * P_WIDTH'($signed(s1_op.b)) + s1_op.c;
    end

    always_ff @(posedge clk_3x) begin
        if (!srst_n) begin
            s1_vld   <= 1'b0;
            s1_op    <= '0;
            s2_vld   <= 1'b0;
            res_id_o <= '0;
            res_p_o  <= '0;
        end else begin
            s1_vld <= |ready_o;
            if (|ready_o)
                s1_op <= gnt_op;
            s2_vld <= s1_vld;
            if (s1_vld) begin
                res_id_o <= s1_op.id;
                res_p_o  <= mac_p;
            end
        end
    end

    assign res_valid_o = s2_vld;
    assign busy_o      = s1_vld | s2_vld;

endmodule

// File: tb/tb_dsp_share_arb.sv
// Directed bench for dsp_share_arb: expected results queued at grant, checked on strobe.
module tb_dsp_share_arb;

    localparam int NREQ = 3;
    localparam int AW   = 25;
    localparam int BW   = 11;
    localparam int PW   = AW + BW;

    typedef struct packed {
        logic [1:0]    id;
        logic [PW-1:0] p;
    } exp_t;

    logic              clk_3x = 1'b0;
    logic              srst_n;
    logic              en_i;
    logic [NREQ-1:0]   valid_i;
    logic [NREQ-1:0]   ready_o;
    logic [NREQ*AW-1:0] a_i;
    logic [NREQ*BW-1:0] b_i;
    logic [NREQ*PW-1:0] c_i;
    logic              res_valid_o;
    logic [1:0]        res_id_o;
    logic [PW-1:0]     res_p_o;
    logic              busy_o;

    int     a_op [NREQ];
    int     b_op [NREQ];
    longint c_op [NREQ];

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [1:0]    last_id;
    logic [PW-1:0] last_p;

    always #5 clk_3x = ~clk_3x;

    dsp_share_arb #(.NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .clk_3x      (clk_3x),
        .srst_n      (srst_n),
        .en_i        (en_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
        .res_valid_o (res_valid_o),
        .res_id_o    (res_id_o),
        .res_p_o     (res_p_o),
        .busy_o      (busy_o)
    );

    always_comb begin
        a_i = '0;
        b_i = '0;
        c_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_i[k*AW +: AW] = a_op[k][AW-1:0];
            b_i[k*BW +: BW] = b_op[k][BW-1:0];
            c_i[k*PW +: PW] = c_op[k][PW-1:0];
        end
    end

    function automatic logic [PW-1:0] model(input int k);
        longint r;
        r = longint'(a_op[k]) * longint'(b_op[k]) + c_op[k];
        return r[PW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int k, input int a, input int b, input longint c);
        a_op[k] = a;
        b_op[k] = b;
        c_op[k] = c;
    endtask

    // One cycle of stimulus: drive, check the grant mid-cycle, queue the expected result.
    task automatic cyc(input logic [2:0] v, input logic en, input logic [2:0] exp_rdy,
                       input string tag, input bit push, input bit use_lit,
                       input logic [PW-1:0] lit_p);
        exp_t e;
        int   k;
        valid_i = v;
        en_i    = en;
        @(negedge clk_3x);
        chk(tag, 64'(ready_o), 64'(exp_rdy));
        if (push && exp_rdy != 3'b000) begin
            k    = exp_rdy[1] ? 1 : (exp_rdy[2] ? 2 : 0);
            e.id = 2'(k);
            e.p  = use_lit ? lit_p : model(k);
            sb.push_back(e);
        end
        @(posedge clk_3x);
        #1;
    endtask

    always @(negedge clk_3x) begin
        if (!srst_n) begin
            last_id = '0;
            last_p  = '0;
        end else if (res_valid_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_result observed=id%0d expected=no_result", res_id_o);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", 64'(res_id_o), 64'(e.id));
                chk("res_p", 64'(res_p_o), 64'(e.p));
            end
            last_id = res_id_o;
            last_p  = res_p_o;
        end else begin
            chk("hold_id", 64'(res_id_o), 64'(last_id));
            chk("hold_p", 64'(res_p_o), 64'(last_p));
        end
    end

    initial begin
        srst_n  = 1'b0;
        en_i    = 1'b1;
        valid_i = 3'b111;
        for (int k = 0; k < NREQ; k++) set_op(k, 0, 0, 0);

        // Reset: no grants, outputs cleared.
        repeat (2) begin
            @(negedge clk_3x);
            chk("rst_ready", 64'(ready_o), 64'd0);
            @(posedge clk_3x);
            #1;
        end
        @(negedge clk_3x);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res_id", 64'(res_id_o), 64'd0);
        chk("rst_res_p", 64'(res_p_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        @(posedge clk_3x);
        #1;
        srst_n  = 1'b1;
        valid_i = 3'b000;

        // Single request with two-cycle latency.
        set_op(0, 3, -2, 10);
        cyc(3'b001, 1'b1, 3'b001, "single_gnt", 1, 1, 36'd4);
        valid_i = 3'b000;
        @(negedge clk_3x);
        chk("lat1_valid", 64'(res_valid_o), 64'd0);
        chk("lat1_busy", 64'(busy_o), 64'd1);
        @(posedge clk_3x);
        #1;
        @(negedge clk_3x);
        chk("lat2_valid", 64'(res_valid_o), 64'd1);
        @(posedge clk_3x);
        #1;

        // Move the pointer back to 0, then full contention.
        set_op(0, 5, -3, 1);
        set_op(1, -7, 4, -2);
        set_op(2, 100, -1, 1000);
        cyc(3'b100, 1'b1, 3'b100, "p2_gnt", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b001, "all_gnt0", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b010, "all_gnt1", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b100, "all_gnt2", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b001, "all_gnt3", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b010, "all_gnt4", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b100, "all_gnt5", 1, 0, '0);

        // Extreme operands: exact most-negative product, then a wrapping sum.
        set_op(0, -(1 << 24), -(1 << 10), 0);
        set_op(1, (1 << 24) - 1, (1 << 10) - 1, (64'sd1 <<< 35) - 1);
        cyc(3'b001, 1'b1, 3'b001, "ext_neg", 1, 1, 36'h4_0000_0000);
        cyc(3'b010, 1'b1, 3'b010, "ext_wrap", 1, 1, 36'd51522829312);

        // Pointer at 2, only port 1 valid: granted, pointer returns to 2.
        cyc(3'b010, 1'b1, 3'b010, "skip_gnt", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b100, "skip_ptr", 1, 0, '0);

        // Enable gate: pending result still drains, pointer holds.
        set_op(0, -9, 9, -1);
        cyc(3'b001, 1'b1, 3'b001, "en_pre_gnt", 1, 0, '0);
        cyc(3'b111, 1'b0, 3'b000, "en_gate", 1, 0, '0);
        cyc(3'b111, 1'b1, 3'b010, "en_ptr", 1, 0, '0);
        valid_i = 3'b000;
        repeat (3) begin
            @(posedge clk_3x);
            #1;
        end

        // Reset one cycle after a grant: that operation never completes.
        cyc(3'b100, 1'b1, 3'b100, "rmf_gnt", 0, 0, '0);
        srst_n  = 1'b0;
        valid_i = 3'b111;
        @(negedge clk_3x);
        chk("rmf_ready", 64'(ready_o), 64'd0);
        @(posedge clk_3x);
        #1;
        srst_n  = 1'b1;
        valid_i = 3'b000;
        @(negedge clk_3x);
        chk("rmf_res_valid", 64'(res_valid_o), 64'd0);
        chk("rmf_res_id", 64'(res_id_o), 64'd0);
        chk("rmf_res_p", 64'(res_p_o), 64'd0);
        chk("rmf_busy", 64'(busy_o), 64'd0);
        @(posedge clk_3x);
        #1;
        @(negedge clk_3x);
        chk("rmf_no_pulse", 64'(res_valid_o), 64'd0);
        @(posedge clk_3x);
        #1;
        cyc(3'b111, 1'b1, 3'b001, "post_rst_gnt", 1, 0, '0);
        valid_i = 3'b000;

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk_3x);
            #1;
        end
        @(negedge clk_3x);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("final_busy", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_share_arb.md
DSP_SHARE_ARB -- requirements
Module: dsp_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requester ports (2..4).
REQ-002 SHALL have parameter A_WIDTH, default 25: signed A operand width.
REQ-003 SHALL have parameter B_WIDTH, default 11: signed B operand width.
REQ-004 SHALL derive P_WIDTH = A_WIDTH+B_WIDTH, the result and C operand width, and ID_WIDTH = clog2(NREQ).
REQ-005 SHALL have port clk_3x, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port srst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port en_i, input, 1: grant enable.
REQ-008 SHALL have port valid_i, input, NREQ: per-requester operation request.
REQ-009 SHALL have port ready_o, output, NREQ: one-hot grant, combinational.
REQ-010 SHALL have port a_i, input, NREQ*A_WIDTH: packed signed A operands, port k at [k*A_WIDTH +: A_WIDTH].
REQ-011 SHALL have port b_i, input, NREQ*B_WIDTH: packed signed B operands, port k at [k*B_WIDTH +: B_WIDTH].
REQ-012 SHALL have port c_i, input, NREQ*P_WIDTH: packed signed addends, port k at [k*P_WIDTH +: P_WIDTH].
REQ-013 SHALL have port res_valid_o, output, 1: result strobe, one cycle per result.
REQ-014 SHALL have port res_id_o, output, ID_WIDTH: index of the requester that owns the result.
REQ-015 SHALL have port res_p_o, output, P_WIDTH: signed result P.
REQ-016 SHALL have port busy_o, output, 1: high while any operation is in flight.

Function
REQ-017 SHALL compute P = A*B + C; C is P_WIDTH wide; the sum wraps modulo 2^P_WIDTH; no saturation.
REQ-018 SHALL grant at most one requester per cycle; ready_o is all-zero when en_i=0 or valid_i=0.
REQ-019 SHALL arbitrate round-robin with pointer ptr: search order ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
REQ-020 SHALL on each handshake (valid_i[k] & ready_o[k]) set ptr <= (k+1) mod NREQ; ptr is unchanged when there is no handshake.
REQ-021 SHALL latch the granted operands and ID into stage 1 on the handshake edge, and register the product/sum into stage 2 on the next edge.
REQ-022 SHALL assert res_valid_o exactly 2 cycles after the handshake edge, with res_id_o/res_p_o valid for that cycle only.
REQ-023 SHALL sustain 1 operation per cycle; results leave in grant order; there is no output backpressure.
REQ-024 SHALL hold res_p_o/res_id_o at their last values while res_valid_o=0.
REQ-025 SHALL keep draining in-flight operations when en_i falls.
REQ-026 SHALL drive busy_o = stage1 valid | stage2 valid.
REQ-027 SHALL have requesters hold operands stable while valid_i is high and not granted; a requester may drop valid_i without a grant.

Reset
REQ-028 SHALL, while srst_n=0 at a clock edge: clear both stage-valid flags, set ptr=0, res_valid_o=0, res_id_o=0, res_p_o=0; busy_o=0 follows.
REQ-029 SHALL force ready_o=0 while srst_n=0.
REQ-030 SHALL discard in-flight operations on reset mid-operation: no res_valid_o pulse for operations issued before reset.

Structure
REQ-031 SHALL place the default widths, the NREQ range limits and the ID-width function in the shared DSP package.
REQ-032 SHALL factor the grant logic and pointer into one sub-module, rr_arbiter (NREQ parameter; valid/en in, one-hot grant out, pointer register inside).

Verification
REQ-033 SHALL cover single request: port 0, a=3, b=-2, c=10 -> ready_o=001 same cycle; 2 cycles later res_valid_o=1, res_id_o=0, res_p_o=4.
REQ-034 SHALL cover all-valid contention: valid_i=111 held 6 cycles -> grants 0,1,2,0,1,2 with one result per cycle in the same ID order.
REQ-035 SHALL cover extreme operands: a=-2^24, b=-2^10, c=0 -> res_p_o=2^34 exact; and a=2^24-1, b=2^10-1, c=2^35-1 -> the sum wraps modulo 2^36.
REQ-036 SHALL cover pointer skip: ptr=2, valid_i=010 -> port 1 granted, ptr becomes 2.
REQ-037 SHALL cover the enable gate: en_i=0 one cycle after a grant, valid_i=111 -> ready_o=000, the pending result is still delivered, ptr is unchanged.
REQ-038 SHALL cover reset mid-flight: grant at cycle 0, srst_n=0 at cycle 1 -> no res_valid_o, outputs 0, busy_o=0, the next grant goes to port 0.
